// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - control bundle between the multicycle controller and its datapath
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7;
    logic       zero;
    logic       negative;
    logic       overflow;
    logic       carry;
    logic       mem_ready;

    logic       mem_req;
    logic       memWrite;
    logic       adrSrc;
    logic       IRwrite;
    logic       PCwrite;
    logic       regWrite;
    logic [1:0] ALUsrcA;
    logic [1:0] ALUsrcB;
    logic [1:0] resultSrc;
    logic [2:0] immSrc;
    logic [3:0] ALUcontrol;
    logic       illegal;

    // Controller side: decodes the instruction and drives the datapath controls
    modport slave (
        input  op, funct3, funct7, zero, negative, overflow, carry, mem_ready,
        output mem_req, memWrite, adrSrc, IRwrite, PCwrite, regWrite,
        output ALUsrcA, ALUsrcB, resultSrc, immSrc, ALUcontrol, illegal
    );

    // Datapath side: supplies instruction fields, flags and memory status
    modport master (
        output op, funct3, funct7, zero, negative, overflow, carry, mem_ready,
        input  mem_req, memWrite, adrSrc, IRwrite, PCwrite, regWrite,
        input  ALUsrcA, ALUsrcB, resultSrc, immSrc, ALUcontrol, illegal
    );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RV32I-style control FSM with retired-instruction counter
module multicycle_controller #(
    parameter int unsigned MEM_HS = 1,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    multicycle_controller_if.slave bus,
    output logic [CNT_W-1:0]       instret
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR,
        EXECI, ALUWB, BRANCH, JAL, JALR, UPPER, TRAP
    } state_t;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SLT  = 4'd9;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic       mem_done;
    logic [3:0] alu_op;
    logic       br_take;
    logic       br_bad;
    logic       lt;

    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [2:0] imm_src;
    logic [3:0] alu_control;

    // Without a handshake every memory access completes in its first cycle
    assign mem_done = (MEM_HS != 0) ? bus.mem_ready : 1'b1;
    assign lt       = bus.negative ^ bus.overflow;

    // ALU operation for register and immediate arithmetic; only R-type may select sub
    always_comb begin
        alu_op = ALU_ADD;
        case (bus.funct3)
            3'b000:  alu_op = (bus.op[5] && bus.funct7) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = bus.funct7 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            default: alu_op = ALU_AND;
        endcase
    end

    // Branch outcome from the flags of the rs1 - rs2 subtraction
    always_comb begin
        br_take = 1'b0;
        br_bad  = 1'b0;
        case (bus.funct3)
            3'b000:  br_take = bus.zero;
            3'b001:  br_take = ~bus.zero;
            3'b100:  br_take = lt;
            3'b101:  br_take = ~lt;
            3'b110:  br_take = ~bus.carry;
            3'b111:  br_take = bus.carry;
            default: br_bad  = 1'b1;
        endcase
    end

    // Next state and per-state datapath controls; enables are forced low while reset is held
    always_comb begin
        state_d     = state_q;
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        adr_src     = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        result_src  = 2'b00;
        imm_src     = 3'b000;
        alu_control = ALU_ADD;

        case (state_q)
            FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem_done) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = 3'b010;
                case (bus.op)
                    7'b0000011, 7'b0100011: state_d = MEMADR;
                    7'b0110011:             state_d = EXECR;
                    7'b0010011:             state_d = EXECI;
                    7'b1100011:             state_d = BRANCH;
                    7'b1101111:             state_d = JAL;
                    7'b1100111:             state_d = JALR;
                    7'b0110111, 7'b0010111: state_d = UPPER;
                    default:                state_d = TRAP;
                endcase
            end
            MEMADR: begin
                // op[5] separates store (0100011) from load (0000011)
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_src   = bus.op[5] ? 3'b001 : 3'b000;
                state_d   = bus.op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_done) state_d = MEMWB;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = FETCH;
            end
            MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (mem_done) state_d = FETCH;
            end
            EXECR: begin
                alu_src_a   = 2'b10;
                alu_control = alu_op;
                state_d     = ALUWB;
            end
            EXECI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = alu_op;
                state_d     = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = ALU_SUB;
                pc_write    = br_take;
                state_d     = br_bad ? TRAP : FETCH;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                reg_write = 1'b1;
                pc_write  = 1'b1;
                state_d   = FETCH;
            end
            JALR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write   = 1'b1;
                reg_write  = 1'b1;
                state_d    = FETCH;
            end
            UPPER: begin
                // op[5] separates lui (0110111) from auipc (0010111)
                imm_src    = 3'b011;
                alu_src_b  = 2'b01;
                alu_src_a  = bus.op[5] ? 2'b11 : 2'b01;
                result_src = 2'b10;
                reg_write  = 1'b1;
                state_d    = FETCH;
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = TRAP;
            end
        endcase

        if (!rst_n) begin
            mem_req   = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
        end
    end

    // An instruction retires whenever the FSM returns to FETCH from another state
    always_comb begin
        instret_d = instret_q;
        if (state_q != FETCH && state_d == FETCH) instret_d = instret_q + CNT_W'(1);
    end

    // State and counter registers; reset wins over any pending memory wait
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    assign bus.mem_req    = mem_req;
    assign bus.memWrite   = mem_write;
    assign bus.adrSrc     = adr_src;
    assign bus.IRwrite    = ir_write;
    assign bus.PCwrite    = pc_write;
    assign bus.regWrite   = reg_write;
    assign bus.ALUsrcA    = alu_src_a;
    assign bus.ALUsrcB    = alu_src_b;
    assign bus.resultSrc  = result_src;
    assign bus.immSrc     = imm_src;
    assign bus.ALUcontrol = alu_control;
    assign bus.illegal    = (state_q == TRAP);
    assign instret        = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for multicycle_controller
module tb_multicycle_controller;

    typedef enum logic [3:0] {K_LOAD, K_STORE, K_R, K_I, K_BR, K_JAL, K_JALR, K_LUI, K_AUIPC} kind_t;

    typedef struct {
        kind_t      k;
        logic [2:0] f3;
        logic       f7;
        logic [3:0] fl;
        int         cyc;
        int         rw;
        int         pcw;
        logic [3:0] alu;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst0_n = 1'b0;
    logic [7:0]  instret1;
    logic [31:0] instret0;

    int n_pass = 0;
    int n_total = 0;

    vec_t       vt[18];
    logic       seq_rdy[16];
    logic [7:0] seq_exp[16];

    multicycle_controller_if bus1();
    multicycle_controller_if bus0();

    multicycle_controller #(.MEM_HS(1), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .instret(instret1)
    );

    multicycle_controller #(.MEM_HS(0), .CNT_W(32)) dut0 (
        .clk(clk), .rst_n(rst0_n), .bus(bus0), .instret(instret0)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    function automatic logic [7:0] sig1();
        return {bus1.mem_req, bus1.adrSrc, bus1.memWrite, bus1.IRwrite,
                bus1.PCwrite, bus1.regWrite, bus1.resultSrc};
    endfunction

    function automatic logic [7:0] sig0();
        return {bus0.mem_req, bus0.adrSrc, bus0.memWrite, bus0.IRwrite,
                bus0.PCwrite, bus0.regWrite, bus0.resultSrc};
    endfunction

    function automatic logic [4:0] en1();
        return {bus1.mem_req, bus1.memWrite, bus1.IRwrite, bus1.PCwrite, bus1.regWrite};
    endfunction

    function automatic logic [6:0] op_of(kind_t k);
        case (k)
            K_LOAD:  return 7'b0000011;
            K_STORE: return 7'b0100011;
            K_R:     return 7'b0110011;
            K_I:     return 7'b0010011;
            K_BR:    return 7'b1100011;
            K_JAL:   return 7'b1101111;
            K_JALR:  return 7'b1100111;
            K_LUI:   return 7'b0110111;
            default: return 7'b0010111;
        endcase
    endfunction

    // Reference model: instruction-level cost and effects
    function automatic int m_cycles(kind_t k, int wf, int wm);
        int c;
        c = wf + 2;
        case (k)
            K_LOAD:   c += wm + 3;
            K_STORE:  c += wm + 2;
            K_R, K_I: c += 2;
            default:  c += 1;
        endcase
        return c;
    endfunction

    function automatic logic m_taken(logic [2:0] f3, logic [7:0] a, logic [7:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a < b;
            default: return a >= b;
        endcase
    endfunction

    function automatic logic [3:0] m_alu(kind_t k, logic [2:0] f3, logic f7);
        if (k == K_BR) return 4'd1;
        if (k != K_R && k != K_I) return 4'd0;
        case (f3)
            3'd0:    return (k == K_R && f7) ? 4'd1 : 4'd0;
            3'd1:    return 4'd5;
            3'd2:    return 4'd9;
            3'd3:    return 4'd7;
            3'd4:    return 4'd4;
            3'd5:    return f7 ? 4'd8 : 4'd6;
            3'd6:    return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    // Runs one instruction on dut from FETCH to the next FETCH, acting as a memory with fixed waits
    task automatic run_instr(input kind_t k, input logic [2:0] f3, input logic f7, input logic [3:0] fl,
                             input int wf, input int wm, output int cycles, output int rw,
                             output int pcw, output int mw, output logic [3:0] alu_x, output logic pcw_x);
        logic [7:0] start;
        logic [7:0] exp_i;
        int run;
        bit fetched;
        bit done;
        start = instret1;
        exp_i = start + 8'd1;
        bus1.op = op_of(k);
        bus1.funct3 = f3;
        bus1.funct7 = f7;
        {bus1.zero, bus1.negative, bus1.overflow, bus1.carry} = fl;
        cycles = 0; rw = 0; pcw = 0; mw = 0; alu_x = 4'hf; pcw_x = 1'b0;
        run = 0; fetched = 0; done = 0;
        while (!done) begin
            @(negedge clk);
            bus1.mem_ready = bus1.mem_req && (run >= (fetched ? wm : wf));
            #1;
            rw  += int'(bus1.regWrite);
            pcw += int'(bus1.PCwrite);
            mw  += int'(bus1.memWrite);
            if (cycles == wf + 2) begin
                alu_x = bus1.ALUcontrol;
                pcw_x = bus1.PCwrite;
            end
            if (bus1.mem_req && !bus1.mem_ready) run++;
            else run = 0;
            if (bus1.IRwrite) fetched = 1;
            cycles++;
            @(posedge clk);
            #1;
            if (instret1 != start) begin
                done = 1;
                chk("instret_step", instret1, exp_i);
            end else if (cycles > 60) begin
                done = 1;
                chk("instr_timeout", 1'b0, 1'b1);
            end
        end
    endtask

    task automatic seq_run(input string name, input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            bus1.mem_ready = seq_rdy[c];
            #1;
            chk($sformatf("%s_c%0d", name, c), sig1(), seq_exp[c]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset1();
        @(negedge clk);
        rst_n = 1'b0;
        bus1.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_illegal", bus1.illegal, 1'b0);
        chk("reset_instret", instret1, 8'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        int cyc, rw, pcw, mw;
        logic [3:0] alu_x;
        logic pcw_x;
        logic [7:0] s;

        vt[0]  = '{K_R,     3'd0, 1'b0, 4'b0000, 4, 1, 1, 4'd0};
        vt[1]  = '{K_R,     3'd0, 1'b1, 4'b0000, 4, 1, 1, 4'd1};
        vt[2]  = '{K_I,     3'd0, 1'b1, 4'b0000, 4, 1, 1, 4'd0};
        vt[3]  = '{K_I,     3'd5, 1'b1, 4'b0000, 4, 1, 1, 4'd8};
        vt[4]  = '{K_R,     3'd5, 1'b0, 4'b0000, 4, 1, 1, 4'd6};
        vt[5]  = '{K_R,     3'd2, 1'b0, 4'b0000, 4, 1, 1, 4'd9};
        vt[6]  = '{K_I,     3'd3, 1'b0, 4'b0000, 4, 1, 1, 4'd7};
        vt[7]  = '{K_R,     3'd4, 1'b0, 4'b0000, 4, 1, 1, 4'd4};
        vt[8]  = '{K_R,     3'd6, 1'b0, 4'b0000, 4, 1, 1, 4'd3};
        vt[9]  = '{K_I,     3'd7, 1'b0, 4'b0000, 4, 1, 1, 4'd2};
        vt[10] = '{K_R,     3'd1, 1'b0, 4'b0000, 4, 1, 1, 4'd5};
        vt[11] = '{K_LOAD,  3'd2, 1'b0, 4'b0000, 5, 1, 1, 4'd0};
        vt[12] = '{K_STORE, 3'd2, 1'b0, 4'b0000, 4, 0, 1, 4'd0};
        vt[13] = '{K_JAL,   3'd0, 1'b0, 4'b0000, 3, 1, 2, 4'd0};
        vt[14] = '{K_BR,    3'd0, 1'b0, 4'b1000, 3, 0, 2, 4'd1};
        vt[15] = '{K_BR,    3'd7, 1'b0, 4'b0000, 3, 0, 1, 4'd1};
        vt[16] = '{K_JALR,  3'd0, 1'b0, 4'b0000, 3, 1, 2, 4'd0};
        vt[17] = '{K_LUI,   3'd0, 1'b0, 4'b0000, 3, 1, 1, 4'd0};

        bus1.op = 7'b0110011; bus1.funct3 = 3'd0; bus1.funct7 = 1'b0;
        {bus1.zero, bus1.negative, bus1.overflow, bus1.carry} = 4'b0000;
        bus1.mem_ready = 1'b0;
        bus0.op = 7'b0110011; bus0.funct3 = 3'd0; bus0.funct7 = 1'b0;
        {bus0.zero, bus0.negative, bus0.overflow, bus0.carry} = 4'b0000;
        bus0.mem_ready = 1'b0;

        // Reset state: no enables while held, FETCH request right after release
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_instret", instret1, 8'd0);
        chk("rst_illegal", bus1.illegal, 1'b0);
        chk("rst_enables", en1(), 5'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_release_fetch", sig1(), 8'b1000_0010);

        // add on the no-handshake instance with mem_ready held low
        rst0_n = 1'b1;
        seq_exp[0] = 8'b1001_1010;
        seq_exp[1] = 8'b0000_0000;
        seq_exp[2] = 8'b0000_0000;
        seq_exp[3] = 8'b0000_0100;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("add_hs0_c%0d", c), sig0(), seq_exp[c]);
            if (c == 2) chk("add_hs0_alu", bus0.ALUcontrol, 4'd0);
            if (c == 3) chk("add_hs0_instret_pre", instret0, 32'd0);
        end
        @(posedge clk);
        #1;
        chk("add_hs0_instret_post", instret0, 32'd1);

        // Table of single instructions with zero memory waits
        for (int i = 0; i < 18; i++) begin
            run_instr(vt[i].k, vt[i].f3, vt[i].f7, vt[i].fl, 0, 0, cyc, rw, pcw, mw, alu_x, pcw_x);
            chk($sformatf("vec%0d_cycles", i), cyc, vt[i].cyc);
            chk($sformatf("vec%0d_regwrite", i), rw, vt[i].rw);
            chk($sformatf("vec%0d_pcwrite", i), pcw, vt[i].pcw);
            chk($sformatf("vec%0d_alu", i), alu_x, vt[i].alu);
        end

        // lw with three wait cycles in MEMREAD
        bus1.op = 7'b0000011; bus1.funct3 = 3'd2;
        seq_rdy[0] = 1; seq_exp[0] = 8'b1001_1010;
        seq_rdy[1] = 0; seq_exp[1] = 8'b0000_0000;
        seq_rdy[2] = 0; seq_exp[2] = 8'b0000_0000;
        seq_rdy[3] = 0; seq_exp[3] = 8'b1100_0000;
        seq_rdy[4] = 0; seq_exp[4] = 8'b1100_0000;
        seq_rdy[5] = 0; seq_exp[5] = 8'b1100_0000;
        seq_rdy[6] = 1; seq_exp[6] = 8'b1100_0000;
        seq_rdy[7] = 0; seq_exp[7] = 8'b0000_0101;
        s = instret1 + 8'd1;
        seq_run("lw_wait", 8);
        chk("lw_instret", instret1, s);
        chk("lw_back_fetch", bus1.mem_req, 1'b1);

        // blt taken and bge not taken with N=1, V=0
        run_instr(K_BR, 3'd4, 1'b0, 4'b0100, 0, 0, cyc, rw, pcw, mw, alu_x, pcw_x);
        chk("blt_pcwrite", pcw_x, 1'b1);
        chk("blt_alu", alu_x, 4'd1);
        run_instr(K_BR, 3'd5, 1'b0, 4'b0100, 0, 0, cyc, rw, pcw, mw, alu_x, pcw_x);
        chk("bge_pcwrite", pcw_x, 1'b0);
        chk("bge_alu", alu_x, 4'd1);

        // Randomized instruction stream against the instruction-level model
        for (int i = 0; i < 150; i++) begin
            kind_t k;
            logic [2:0] f3;
            logic f7;
            logic [7:0] a, b, d;
            logic [3:0] fl;
            int wf, wm;
            logic tk;
            k  = kind_t'($urandom_range(0, 8));
            f3 = 3'($urandom_range(0, 7));
            f7 = 1'($urandom_range(0, 1));
            if (k == K_BR && (f3 == 3'd2 || f3 == 3'd3)) f3 = f3 + 3'd2;
            a  = 8'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? a : 8'($urandom);
            d  = a - b;
            fl = {d == 8'd0, d[7], (a[7] != b[7]) && (d[7] != a[7]), a >= b};
            wf = $urandom_range(0, 3);
            wm = $urandom_range(0, 3);
            tk = (k == K_BR) && m_taken(f3, a, b);
            run_instr(k, f3, f7, fl, wf, wm, cyc, rw, pcw, mw, alu_x, pcw_x);
            chk($sformatf("rand%0d_cycles", i), cyc, m_cycles(k, wf, wm));
            chk($sformatf("rand%0d_regwrite", i), rw, (k == K_STORE || k == K_BR) ? 0 : 1);
            chk($sformatf("rand%0d_pcwrite", i), pcw,
                1 + ((k == K_JAL || k == K_JALR) ? 1 : 0) + (tk ? 1 : 0));
            chk($sformatf("rand%0d_memwrite", i), mw, (k == K_STORE) ? wm + 1 : 0);
            chk($sformatf("rand%0d_alu", i), alu_x, m_alu(k, f3, f7));
            if (k == K_BR) chk($sformatf("rand%0d_taken", i), pcw_x, tk);
        end

        // Unknown opcode traps and holds until reset
        bus1.op = 7'b0000000;
        @(negedge clk); bus1.mem_ready = 1'b1;
        @(negedge clk); bus1.mem_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            bus1.mem_ready = c[0];
            #1;
            chk($sformatf("trap_hold_c%0d", c), {bus1.illegal, en1()}, 6'b100000);
        end
        reset1();
        #1;
        chk("trap_reset_fetch", bus1.mem_req, 1'b1);

        // Branch with funct3 010 is illegal
        bus1.op = 7'b1100011; bus1.funct3 = 3'd2;
        {bus1.zero, bus1.negative, bus1.overflow, bus1.carry} = 4'b1111;
        @(negedge clk); bus1.mem_ready = 1'b1;
        @(negedge clk); bus1.mem_ready = 1'b0;
        @(negedge clk); #1;
        chk("br010_pcwrite", bus1.PCwrite, 1'b0);
        @(posedge clk); #1;
        chk("br010_illegal", bus1.illegal, 1'b1);
        reset1();

        // Reset in the middle of a MEMWRITE wait
        bus1.op = 7'b0100011; bus1.funct3 = 3'd2;
        @(negedge clk); bus1.mem_ready = 1'b1;
        @(negedge clk); bus1.mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        chk("sw_wait_memwrite0", bus1.memWrite, 1'b1);
        @(negedge clk); #1;
        chk("sw_wait_memwrite1", bus1.memWrite, 1'b1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("sw_reset_memwrite", bus1.memWrite, 1'b0);
        chk("sw_reset_instret", instret1, 8'd0);
        rst_n = 1'b1;
        #1;
        chk("sw_reset_fetch", {bus1.mem_req, bus1.memWrite, bus1.adrSrc}, 3'b100);

        // 256 retired adds wrap the 8-bit counter
        for (int i = 0; i < 256; i++) begin
            run_instr(K_R, 3'd0, 1'b0, 4'b0000, 0, 0, cyc, rw, pcw, mw, alu_x, pcw_x);
            if (i == 254) chk("wrap_255", instret1, 8'd255);
        end
        chk("wrap_zero", instret1, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
